// File: rtl/note_scheduler.sv
// note_scheduler
//   Walks a note-chart ROM in address order and issues each entry once the
//   song clock comes within LOOKAHEAD ticks of the entry's timestamp.
//   An entry whose lane mask is zero marks the end of the chart.
//
// Ports
//   clk          system clock
//   reset_n      synchronous active-low reset; clears every register
//   game_reset   synchronous restart from chart entry 0 (active-high)
//   pause        holds the look-ahead check; a note already offered stays up
//   song_time    current song time in ticks
//   rom_addr     registered chart ROM address
//   rom_data     ROM word {time, lanes}, valid the cycle after rom_addr moves
//   note_valid   issued note on offer
//   note_ready   downstream accepts the offered note
//   note_time    timestamp of the offered note
//   note_lanes   lane mask of the offered note
//   chart_done   end of chart reached (level)
//   notes_issued accepted-note count, saturating at 16'hFFFF
module note_scheduler #(
    parameter int unsigned TIME_W    = 20,
    parameter int unsigned LANES     = 5,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned LOOKAHEAD = 2000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    game_reset,
    input  logic                    pause,
    input  logic [TIME_W-1:0]       song_time,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [TIME_W+LANES-1:0] rom_data,
    output logic                    note_valid,
    input  logic                    note_ready,
    output logic [TIME_W-1:0]       note_time,
    output logic [LANES-1:0]        note_lanes,
    output logic                    chart_done,
    output logic [15:0]             notes_issued
);

    localparam logic [2:0] FETCH = 3'd0;
    localparam logic [2:0] LATCH = 3'd1;
    localparam logic [2:0] CHECK = 3'd2;
    localparam logic [2:0] EMIT  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [TIME_W:0] LOOK_EXT = (TIME_W + 1)'(LOOKAHEAD);

    logic [2:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [TIME_W:0]   deadline;
    logic              due;

    // One extra bit keeps song_time + LOOKAHEAD from wrapping near the top
    // of the time range, which would otherwise hide a due note.
    always_comb begin
        deadline = {1'b0, song_time} + LOOK_EXT;
        due      = !pause && ({1'b0, note_time} <= deadline);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= FETCH;
            ptr          <= '0;
            rom_addr     <= '0;
            note_valid   <= 1'b0;
            note_time    <= '0;
            note_lanes   <= '0;
            chart_done   <= 1'b0;
            notes_issued <= '0;
        end else if (game_reset) begin
            // Overrides a same-cycle acceptance: the offered note is dropped.
            state        <= FETCH;
            ptr          <= '0;
            note_valid   <= 1'b0;
            chart_done   <= 1'b0;
            notes_issued <= '0;
        end else begin
            case (state)
                FETCH: begin
                    rom_addr <= ptr;
                    state    <= LATCH;
                end
                LATCH: begin
                    note_time  <= rom_data[TIME_W+LANES-1:LANES];
                    note_lanes <= rom_data[LANES-1:0];
                    if (rom_data[LANES-1:0] == '0) begin
                        state      <= DONE;
                        chart_done <= 1'b1;
                    end else begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (due) begin
                        state      <= EMIT;
                        note_valid <= 1'b1;
                    end
                end
                EMIT: begin
                    if (note_ready) begin
                        note_valid <= 1'b0;
                        ptr        <= ptr + ADDR_W'(1);
                        if (notes_issued != 16'hFFFF) begin
                            notes_issued <= notes_issued + 16'd1;
                        end
                        // Last ROM address consumed without a marker.
                        if (ptr == '1) begin
                            state      <= DONE;
                            chart_done <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: doc/note_scheduler.md
# note_scheduler

Chart-playback stage directly downstream of the game control block. Consumes the running `song_time`, `pause` and game `reset` it produces, walks a note-chart ROM in order, and issues each chart entry to the display/scoring pipeline once the song reaches that entry's timestamp minus a fixed look-ahead. It owns the ROM read pointer, the look-ahead comparison, a valid/ready output handshake and end-of-chart detection.

## Interface
- `TIME_W`, 20: width of `song_time` and chart timestamps (ms ticks).
- `LANES`, 5: number of note lanes (bits in lane mask).
- `ADDR_W`, 10: chart ROM address width.
- `LOOKAHEAD`, 2000: ticks before its timestamp that a note is issued.

- `clk` in 1: 100 MHz system clock.
- `reset_n` in 1: synchronous, active-low reset.
- `game_reset` in 1: control-block reset status; synchronous restart, active-high.
- `pause` in 1: control-block pause status.
- `song_time` in TIME_W: current song time from the song timer.
- `rom_addr` out ADDR_W: registered chart ROM address.
- `rom_data` in TIME_W+LANES: ROM word `{time, lanes}`, valid one cycle after `rom_addr` changes.
- `note_valid` out 1: issued note available.
- `note_ready` in 1: downstream accepts note.
- `note_time` out TIME_W: timestamp of issued note.
- `note_lanes` out LANES: lane mask of issued note.
- `chart_done` out 1: end of chart reached; level.
- `notes_issued` out 16: count of accepted notes, saturating at 16'hFFFF.

## Operation
- FSM states: FETCH, LATCH, CHECK, EMIT, DONE.
- FETCH: `rom_addr <= ptr`; next state LATCH (one cycle).
- LATCH: capture `rom_data` into `note_time`/`note_lanes`. If lanes == 0, it is an end marker: go to DONE. Otherwise go to CHECK.
- CHECK: go to EMIT when `!pause` and `{1'b0,note_time} <= {1'b0,song_time} + LOOKAHEAD`. The sum is computed at TIME_W+1 bits and must not wrap. Otherwise stay in CHECK.
- EMIT: `note_valid` = 1.
  - On `note_ready`: increment `notes_issued` and `ptr`.
  - Then go to DONE if `ptr` was all-ones, else FETCH.
  - `note_valid`, `note_time` and `note_lanes` are stable until accepted.
  - Pause does not withdraw an asserted note.
- DONE: `chart_done` = 1; hold until `game_reset` or `reset_n`.
- Late notes are issued as soon as they are reached. Catch-up at start issues them back-to-back at the handshake rate.
- `game_reset` (high on a clock edge, `reset_n` high):
  - from any state: ptr = 0, state = FETCH;
  - `note_valid` and `chart_done` = 0 next cycle (this is the only case where `note_valid` drops without `note_ready`);
  - `notes_issued` = 0.
  - While held high, the block restarts every cycle.
- `reset_n` low has priority over `game_reset`. Same effect, plus `rom_addr` = 0, `note_time` = 0, `note_lanes` = 0.

## Timing
- Reset values: `rom_addr` 0, `note_valid` 0, `note_time` 0, `note_lanes` 0, `chart_done` 0, `notes_issued` 0, state FETCH.
- All outputs are registered; none is combinational from inputs.
- Minimum note spacing: 4 cycles from one acceptance to the next `note_valid` (EMIT→FETCH→LATCH→CHECK→EMIT), with `note_ready` tied high.
- Latency from the cycle CHECK sees the condition true to `note_valid` high: 1 cycle.
- After reset release: first `note_valid` no earlier than cycle 3.
- `chart_done` rises the cycle after LATCH detects an end marker, or the cycle after acceptance of the entry at address 2^ADDR_W−1.
- Simultaneous `note_ready` and `game_reset`: `game_reset` wins. The note counts as not accepted and `notes_issued` clears.
- `pause` toggling while in CHECK only gates the transition. There is no internal timekeeping.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles with random inputs. Required: all outputs at reset values; `rom_addr`=0 on the first cycle after release.
- Look-ahead: chart {3000,5'b00001}, {3500,5'b00110}, end marker; ramp `song_time`, `note_ready`=1. Required:
  - note 1 valid the cycle after CHECK sees `song_time`=1000;
  - note 2 at 1500;
  - `chart_done` after the marker;
  - `notes_issued`=2.
- Backpressure and pause: `note_ready`=0 for 10 cycles with `pause` toggling. Required: `note_valid`, `note_time` and `note_lanes` held constant; acceptance on the first `note_ready`=1; no note issued while `pause`=1 in CHECK.
- Catch-up: `song_time`=10000 and chart of five notes at 100..500. Required: five notes accepted at 4-cycle spacing, in ROM order.
- `game_reset` during EMIT with `note_ready`=1 in the same cycle. Required: `note_valid`=0 next cycle, `notes_issued`=0, `rom_addr` returns to 0, and the chart replays from entry 0.
- Overflow and last address: `song_time`=2^20−1 with `note_time`=2^20−1. Required: issued, with no wrap false-negative. A chart filling all 1024 entries with no marker gives `chart_done` after the 1024th acceptance.
